// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives InstMemory and loads the IF/ID register.
// Optional fetch/bubble performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int unsigned ADDR_BITS = 5,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          pc,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_instr,
  output logic                 if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_bubbles
`endif
);

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        fetch_take_c;
  logic        redirect_take_c;

  // Redirect beats stall; a stall freezes the whole stage.
  always_comb begin
    pc_d            = pc_q;
    if_id_pc_d      = if_id_pc_q;
    if_id_instr_d   = if_id_instr_q;
    if_id_valid_d   = if_id_valid_q;
    fetch_take_c    = 1'b0;
    redirect_take_c = 1'b0;
    if (redirect_valid) begin
      redirect_take_c = 1'b1;
      pc_d            = redirect_pc & ALIGN_MASK;
      if_id_pc_d      = pc_q;
      if_id_instr_d   = NOP_INSTR;
      if_id_valid_d   = 1'b0;
    end else if (!stall) begin
      fetch_take_c    = 1'b1;
      pc_d            = pc_q + PC_STEP;
      if_id_pc_d      = pc_q;
      if_id_instr_d   = imem_rdata;
      if_id_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr   = pc_q[ADDR_BITS-1:0];
  assign pc          = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (fetch_take_c)    perf_fetched_d = perf_fetched_q + 32'd1;
    if (redirect_take_c) perf_bubbles_d = perf_bubbles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic unused_c;
  assign unused_c = fetch_take_c ^ redirect_take_c;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect/reset traffic.
module tb_fetch_stage;

  localparam int unsigned AW    = 5;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   pc;
  logic [31:0]   if_id_pc;
  logic [31:0]   if_id_instr;
  logic          if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_bubbles;
`endif

  logic [31:0] mem [DEPTH];
  assign imem_rdata = mem[imem_addr];

  fetch_stage #(.ADDR_BITS(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state of the stage.
  logic [31:0] m_pc = 32'd0, m_ifpc = 32'd0, m_instr = NOP;
  logic        m_valid = 1'b0;
  logic [31:0] m_fetched = 32'd0, m_bubbles = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (!rst_n) begin
      m_pc = 32'd0; m_ifpc = 32'd0; m_instr = NOP; m_valid = 1'b0;
      m_fetched = 32'd0; m_bubbles = 32'd0;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_ifpc = old_pc; m_instr = NOP; m_valid = 1'b0;
      m_bubbles = m_bubbles + 32'd1;
    end else if (!stall) begin
      m_ifpc = old_pc;
      m_instr = mem[old_pc % DEPTH];
      m_valid = 1'b1;
      m_pc = old_pc + 32'd4;
      m_fetched = m_fetched + 32'd1;
    end
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("imem_addr", 32'(imem_addr), m_pc % DEPTH);
    check("if_id_pc", if_id_pc, m_ifpc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_bubbles", perf_bubbles, m_bubbles);
`endif
  endtask

  // One clock: model follows the edge, then outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h1000_0000 + 32'(i);

    step(); step();
    check("rst_pc", pc, 32'd0);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_ifpc", if_id_pc, 32'd0);

    rst_n = 1'b1;
    check("first_addr", 32'(imem_addr), 32'd0);
    step();
    check("f1_valid", 32'(if_id_valid), 32'd1);
    check("f1_ifpc", if_id_pc, 32'd0);
    check("f1_instr", if_id_instr, 32'h1000_0000);
    check("f1_addr", 32'(imem_addr), 32'd4);
    step();
    check("f2_ifpc", if_id_pc, 32'd4);
    check("f2_instr", if_id_instr, 32'h1000_0004);
    check("f2_addr", 32'(imem_addr), 32'd8);

    stall = 1'b1;
    repeat (3) begin
      step();
      check("stall_pc", pc, 32'd8);
      check("stall_ifpc", if_id_pc, 32'd4);
      check("stall_instr", if_id_instr, 32'h1000_0004);
      check("stall_valid", 32'(if_id_valid), 32'd1);
    end
    stall = 1'b0;
    step();
    check("unstall_ifpc", if_id_pc, 32'd8);
    check("unstall_instr", if_id_instr, 32'h1000_0008);
    check("unstall_pc", pc, 32'd12);

    redirect_valid = 1'b1; redirect_pc = 32'h0000_0006;
    step();
    redirect_valid = 1'b0;
    check("redir_pc", pc, 32'd4);
    check("redir_valid", 32'(if_id_valid), 32'd0);
    check("redir_instr", if_id_instr, NOP);
    step();
    check("post_redir_ifpc", if_id_pc, 32'd4);
    check("post_redir_instr", if_id_instr, 32'h1000_0004);
    check("post_redir_valid", 32'(if_id_valid), 32'd1);

    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd16;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    check("rs_pc", pc, 32'd16);
    check("rs_valid", 32'(if_id_valid), 32'd0);
    step();
    check("rs_next_ifpc", if_id_pc, 32'd16);
    check("rs_next_pc", pc, 32'd20);

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pre_addr", 32'(imem_addr), 32'd28);
    step();
    check("wrap_pc", pc, 32'd0);
    check("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_instr", if_id_instr, 32'h1000_001C);

    step();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    rst_n = 1'b1; redirect_valid = 1'b0; stall = 1'b0;
    check("midrst_pc", pc, 32'd0);
    check("midrst_valid", 32'(if_id_valid), 32'd0);

    repeat (5) step();
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0; stall = 1'b1;
    repeat (2) step();
    stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched_5", perf_fetched, 32'd5);
    check("perf_bubbles_1", perf_bubbles, 32'd1);
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched_rst", perf_fetched, 32'd0);
    check("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      stall          = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
